// File: rtl/byte_striping_nlane_pkg.sv
// Shared definitions for the N-lane byte-striping and un-striping blocks:
// lane-count legality range, lane index width helper and pointer actions.
package byte_striping_nlane_pkg;

    // Legal range for NUM_LANES on both the striping and un-striping sides.
    localparam int MIN_LANES = 2;
    localparam int MAX_LANES = 8;

    // Width of a lane index; never narrower than one bit.
    function automatic int lane_idx_w(input int num_lanes);
        return (num_lanes <= 1) ? 1 : $clog2(num_lanes);
    endfunction

    // What happens to the lane pointer on the next edge.
    typedef enum logic [1:0] {
        PTR_HOLD    = 2'd0,
        PTR_ADVANCE = 2'd1,
        PTR_FLUSH   = 2'd2,
        PTR_REALIGN = 2'd3
    } ptr_action_e;

endpackage

// File: rtl/byte_striping_nlane_lane_ctrl.sv
// Lane pointer control for the N-lane striper: owns the pointer, the idle
// counter and the flush / realign / advance priority. Produces a one-hot
// lane write enable and a flag marking a write to the last lane of a round.
module stripe_lane_ctrl
    import byte_striping_nlane_pkg::*;
#(
    parameter int NUM_LANES    = 2,
    parameter int IDLE_REALIGN = 2,
    localparam int PW          = lane_idx_w(NUM_LANES)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid_in,
    input  logic                 flush,
    output logic [PW-1:0]        lane_ptr,
    output logic [NUM_LANES-1:0] write_en,
    output logic                 last_lane
);

    // Idle counter only needs to reach IDLE_REALIGN, where it saturates.
    localparam int CW = (IDLE_REALIGN < 1) ? 1 : $clog2(IDLE_REALIGN + 1);
    localparam logic [CW-1:0] IDLE_MAX  = CW'(IDLE_REALIGN);
    localparam logic [CW-1:0] IDLE_LAST = (IDLE_REALIGN < 1) ? '0 : CW'(IDLE_REALIGN - 1);
    localparam logic [PW-1:0] LAST_LANE = PW'(NUM_LANES - 1);

    logic [CW-1:0] idle_cnt;
    logic [PW-1:0] target_lane;
    logic          idle_hit;
    ptr_action_e   action;

    // Decode the lane to write and the pointer action; flush beats realign beats advance.
    always_comb begin
        target_lane = flush ? '0 : lane_ptr;
        write_en    = '0;
        if (valid_in) begin
            write_en = NUM_LANES'(1) << target_lane;
        end
        // A flushed word lands on lane 0, which is never the last lane, so no round strobe.
        last_lane = valid_in && !flush && (lane_ptr == LAST_LANE);
        // The idle cycle that makes the counter reach IDLE_REALIGN also resets the pointer.
        idle_hit  = (IDLE_REALIGN != 0) && !valid_in && (idle_cnt >= IDLE_LAST);
        if (flush) begin
            action = PTR_FLUSH;
        end else if (valid_in) begin
            action = PTR_ADVANCE;
        end else if (idle_hit) begin
            action = PTR_REALIGN;
        end else begin
            action = PTR_HOLD;
        end
    end

    // Pointer and idle counter state.
    always_ff @(posedge clk) begin
        if (reset) begin
            lane_ptr <= '0;
            idle_cnt <= '0;
        end else begin
            case (action)
                PTR_FLUSH:   lane_ptr <= valid_in ? PW'(1) : '0;
                PTR_ADVANCE: lane_ptr <= (lane_ptr == LAST_LANE) ? '0 : lane_ptr + PW'(1);
                PTR_REALIGN: lane_ptr <= '0;
                default:     lane_ptr <= lane_ptr;
            endcase
            if (valid_in) begin
                idle_cnt <= '0;
            end else if ((IDLE_REALIGN != 0) && (idle_cnt != IDLE_MAX)) begin
                idle_cnt <= idle_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/byte_striping_nlane.sv
// N-lane byte-striping stage in the clk_2f domain. Valid input words are
// distributed round-robin over NUM_LANES lane registers; each lane holds its
// last word while lane_valid pulses for one cycle on every write.
module byte_striping_nlane
    import byte_striping_nlane_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_LANES    = 2,
    parameter int IDLE_REALIGN = 2,
    localparam int PW          = lane_idx_w(NUM_LANES)
) (
    input  logic                            clk_2f,
    input  logic                            reset,
    input  logic                            valid_in,
    input  logic [DATA_WIDTH-1:0]           Data_in,
    input  logic                            flush,
    output logic [NUM_LANES*DATA_WIDTH-1:0] lane_data,
    output logic [NUM_LANES-1:0]            lane_valid,
    output logic [PW-1:0]                   lane_ptr,
    output logic                            round_done
);

    // Reject lane counts outside the supported range at elaboration.
    if ((NUM_LANES < MIN_LANES) || (NUM_LANES > MAX_LANES)) begin : g_bad_lanes
        $error("byte_striping_nlane: NUM_LANES out of range");
    end

    logic [NUM_LANES-1:0]  write_en;
    logic                  last_lane;
    logic [DATA_WIDTH-1:0] lane_regs [NUM_LANES];

    stripe_lane_ctrl #(
        .NUM_LANES    (NUM_LANES),
        .IDLE_REALIGN (IDLE_REALIGN)
    ) u_ctrl (
        .clk       (clk_2f),
        .reset     (reset),
        .valid_in  (valid_in),
        .flush     (flush),
        .lane_ptr  (lane_ptr),
        .write_en  (write_en),
        .last_lane (last_lane)
    );

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        // Lane register loads only on its own write enable, so idle-cycle data never reaches it.
        always_ff @(posedge clk_2f) begin
            if (reset) begin
                lane_regs[k] <= '0;
            end else if (write_en[k]) begin
                lane_regs[k] <= Data_in;
            end
        end
        assign lane_data[k*DATA_WIDTH +: DATA_WIDTH] = lane_regs[k];
    end

    // One-cycle strobes that accompany each lane write and each completed round.
    always_ff @(posedge clk_2f) begin
        if (reset) begin
            lane_valid <= '0;
            round_done <= 1'b0;
        end else begin
            lane_valid <= write_en;
            round_done <= last_lane;
        end
    end

endmodule

// File: tb/tb_byte_striping_nlane.sv
// Bench for byte_striping_nlane: three configurations driven in parallel
// with directed steps followed by random traffic, checked against a model.
module tb_byte_striping_nlane;

    localparam int W  = 32;
    localparam int NC = 3;

    logic         clk_2f = 1'b0;
    logic         reset;
    logic         valid_in;
    logic         flush;
    logic [W-1:0] data_in;

    always #5 clk_2f = ~clk_2f;

    // cfg0: 2 lanes, realign 2; cfg1: 3 lanes, realign 2; cfg2: 5 lanes, no realign
    logic [2*W-1:0] d0_data;
    logic [1:0]     d0_valid;
    logic [0:0]     d0_ptr;
    logic           d0_rd;
    logic [3*W-1:0] d1_data;
    logic [2:0]     d1_valid;
    logic [1:0]     d1_ptr;
    logic           d1_rd;
    logic [5*W-1:0] d2_data;
    logic [4:0]     d2_valid;
    logic [2:0]     d2_ptr;
    logic           d2_rd;

    byte_striping_nlane #(.DATA_WIDTH(W), .NUM_LANES(2), .IDLE_REALIGN(2)) dut0 (
        .clk_2f(clk_2f), .reset(reset), .valid_in(valid_in), .Data_in(data_in), .flush(flush),
        .lane_data(d0_data), .lane_valid(d0_valid), .lane_ptr(d0_ptr), .round_done(d0_rd));
    byte_striping_nlane #(.DATA_WIDTH(W), .NUM_LANES(3), .IDLE_REALIGN(2)) dut1 (
        .clk_2f(clk_2f), .reset(reset), .valid_in(valid_in), .Data_in(data_in), .flush(flush),
        .lane_data(d1_data), .lane_valid(d1_valid), .lane_ptr(d1_ptr), .round_done(d1_rd));
    byte_striping_nlane #(.DATA_WIDTH(W), .NUM_LANES(5), .IDLE_REALIGN(0)) dut2 (
        .clk_2f(clk_2f), .reset(reset), .valid_in(valid_in), .Data_in(data_in), .flush(flush),
        .lane_data(d2_data), .lane_valid(d2_valid), .lane_ptr(d2_ptr), .round_done(d2_rd));

    // Reference model: per configuration, position within the current round,
    // length of the current idle run and the last word stored on each lane.
    int           n_of  [NC] = '{2, 3, 5};
    int           ir_of [NC] = '{2, 2, 0};
    int           m_pos [NC];
    int           m_idle[NC];
    logic [W-1:0] m_data[NC][8];
    logic [7:0]   m_valid[NC];
    logic         m_rd  [NC];

    int checks = 0;
    int fails  = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic v, input logic f, input logic [W-1:0] d);
        for (int c = 0; c < NC; c++) begin
            m_valid[c] = '0;
            m_rd[c]    = 1'b0;
            if (r) begin
                m_pos[c]  = 0;
                m_idle[c] = 0;
                for (int k = 0; k < 8; k++) m_data[c][k] = '0;
            end else if (v) begin
                int lane;
                lane          = f ? 0 : m_pos[c];
                m_data[c][lane] = d;
                m_valid[c]    = 8'(1 << lane);
                m_rd[c]       = !f && (lane == n_of[c] - 1);
                m_pos[c]      = (lane + 1) % n_of[c];
                m_idle[c]     = 0;
            end else begin
                if (ir_of[c] != 0 && m_idle[c] < ir_of[c]) m_idle[c]++;
                if (f || (ir_of[c] != 0 && m_idle[c] == ir_of[c])) m_pos[c] = 0;
            end
        end
    endtask

    task automatic check_all(input string name);
        for (int c = 0; c < NC; c++) begin
            logic [255:0] exp_data;
            logic [255:0] obs_data;
            logic [255:0] obs_valid;
            logic [255:0] obs_ptr;
            logic [255:0] obs_rd;
            exp_data = '0;
            for (int k = 0; k < n_of[c]; k++) exp_data[k*W +: W] = m_data[c][k];
            case (c)
                0: begin obs_data = 256'(d0_data); obs_valid = 256'(d0_valid);
                         obs_ptr = 256'(d0_ptr); obs_rd = 256'(d0_rd); end
                1: begin obs_data = 256'(d1_data); obs_valid = 256'(d1_valid);
                         obs_ptr = 256'(d1_ptr); obs_rd = 256'(d1_rd); end
                default: begin obs_data = 256'(d2_data); obs_valid = 256'(d2_valid);
                         obs_ptr = 256'(d2_ptr); obs_rd = 256'(d2_rd); end
            endcase
            check($sformatf("%s/cfg%0d/lane_data", name, c), obs_data, exp_data);
            check($sformatf("%s/cfg%0d/lane_valid", name, c), obs_valid, 256'(m_valid[c]));
            check($sformatf("%s/cfg%0d/lane_ptr", name, c), obs_ptr, 256'(m_pos[c]));
            check($sformatf("%s/cfg%0d/round_done", name, c), obs_rd, 256'(m_rd[c]));
        end
    endtask

    task automatic step(input string name, input logic r, input logic v, input logic f,
                        input logic [W-1:0] d);
        reset    = r;
        valid_in = v;
        flush    = f;
        data_in  = d;
        @(posedge clk_2f);
        model_edge(r, v, f, d);
        #1;
        check_all(name);
    endtask

    initial begin
        logic [W-1:0] xword;
        xword    = 'x;
        reset    = 1'b1;
        valid_in = 1'b0;
        flush    = 1'b0;
        data_in  = '0;

        // Reset state
        step("reset", 1, 0, 0, 0);
        step("reset", 1, 0, 0, 0);

        // Back-to-back words on two lanes
        step("t1", 0, 1, 0, 32'hFFFFFFFF);
        step("t1", 0, 1, 0, 32'hEEEEEEEE);
        check("t1/rd_2nd", 256'(d0_rd), 256'(1));
        step("t1", 0, 1, 0, 32'hDDDDDDDD);
        step("t1", 0, 1, 0, 32'hCCCCCCCC);
        check("t1/lanes", 256'(d0_data), 256'({32'hCCCCCCCC, 32'hDDDDDDDD}));
        check("t1/rd_4th", 256'(d0_rd), 256'(1));

        // Seven words across three lanes
        step("t2", 1, 0, 0, 0);
        for (int i = 1; i <= 7; i++) step("t2", 0, 1, 0, W'(i));
        check("t2/ptr", 256'(d1_ptr), 256'(1));
        check("t2/lanes", 256'(d1_data), 256'({32'd6, 32'd5, 32'd7}));

        // Idle realign after two idle cycles
        step("t3", 1, 0, 0, 0);
        step("t3", 0, 1, 0, 32'd3);
        step("t3", 0, 0, 0, 0);
        step("t3", 0, 0, 0, 0);
        step("t3", 0, 1, 0, 32'd4);
        check("t3/realign_lane0", 256'(d0_valid), 256'(2'b01));
        // One idle cycle keeps the pointer
        step("t3b", 1, 0, 0, 0);
        step("t3b", 0, 1, 0, 32'd3);
        step("t3b", 0, 0, 0, 0);
        step("t3b", 0, 1, 0, 32'd4);
        check("t3b/no_realign_lane1", 256'(d0_valid), 256'(2'b10));

        // Flush with a word while pointer is 1
        step("t4", 1, 0, 0, 0);
        step("t4", 0, 1, 0, 32'h11111111);
        step("t4", 0, 1, 1, 32'hAAAAAAAA);
        check("t4/flush_lane0", 256'(d0_valid), 256'(2'b01));
        check("t4/flush_ptr", 256'(d0_ptr), 256'(1));
        check("t4/flush_no_rd", 256'(d0_rd), 256'(0));
        // Flush without a word
        step("t4b", 0, 1, 0, 32'h22222222);
        step("t4b", 0, 1, 0, 32'h33333333);
        step("t4b", 0, 0, 1, 32'h44444444);
        step("t4b", 0, 1, 0, 32'h55555555);

        // Reset mid-round drops the in-flight word
        step("t5", 0, 1, 0, 32'h66666666);
        step("t5", 1, 1, 0, 32'h99999999);
        check("t5/no_valid", 256'(d1_valid), 256'(0));
        check("t5/data_clear", 256'(d1_data), 256'(0));

        // Unknown data while idle
        step("t6", 0, 1, 0, 32'h12345678);
        for (int i = 0; i < 5; i++) step("t6", 0, 0, 0, xword);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic r, v, f;
            r = ($urandom_range(0, 99) == 0);
            v = ($urandom_range(0, 9) < 6);
            f = ($urandom_range(0, 15) == 0);
            step("rand", r, v, f, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
